// File: rtl/keypad_pkg.sv
// Shared types and matrix helpers for the keypad event scanner.
package keypad_pkg;

    localparam int unsigned MAX_KEYS   = 64;
    localparam int unsigned MAX_CODE_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT,
        ST_MULTI
    } scan_state_t;

    typedef enum logic [1:0] {
        KC_NONE,
        KC_SINGLE,
        KC_MULTI
    } key_class_t;

    typedef struct packed {
        logic                  is_repeat;
        logic                  is_release;
        logic [MAX_CODE_W-1:0] code;
    } key_event_t;

    // Saturating popcount: none, exactly one, or more than one key closed.
    function automatic key_class_t matrix_class(input logic [MAX_KEYS-1:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (m[i] && n < 2) n++;
        end
        if (n == 0)      return KC_NONE;
        else if (n == 1) return KC_SINGLE;
        else             return KC_MULTI;
    endfunction

    function automatic logic [MAX_CODE_W-1:0] lowest_set(input logic [MAX_KEYS-1:0] m);
        logic [MAX_CODE_W-1:0] idx;
        logic                  found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (m[i] && !found) begin
                idx   = MAX_CODE_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO with a registered head word and sticky overflow flag.
module key_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q, wr_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d, left_c;
    logic             pop_c, full_c, wr_en_c, ovf_d;
    logic [WIDTH-1:0] head_d;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_c   = valid & ready;
        full_c  = (cnt_q == CW'(DEPTH));
        wr_en_c = push && (!full_c || pop_c);
        rd_d    = rd_q + AW'(pop_c);
        left_c  = cnt_q - CW'(pop_c);
        cnt_d   = left_c + CW'(wr_en_c);
        if (left_c != '0)  head_d = mem[rd_d];
        else if (wr_en_c)  head_d = push_data;
        else               head_d = '0;
        ovf_d = ovf;
        if (ovf_clr)            ovf_d = 1'b0;
        if (push && !wr_en_c)   ovf_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (wr_en_c) mem[wr_q] <= push_data;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            valid <= 1'b0;
            head  <= '0;
            ovf   <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_q + AW'(wr_en_c);
            cnt_q <= cnt_d;
            valid <= (cnt_d != '0);
            head  <= head_d;
            ovf   <= ovf_d;
        end
    end

endmodule

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: column drive, frame debounce, key event FSM and event FIFO.
module keypad_event_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_RATE     = 10,
    localparam int unsigned CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ROWS-1:0]   key_r,
    output logic [COLS-1:0]   key_c,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_release,
    output logic              ev_repeat,
    output logic              key_down,
    output logic [CODE_W-1:0] key_code,
    output logic              ghost,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned NKEYS   = ROWS * COLS;
    localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned STAB_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [SLOT_W-1:0] slot_q;
    logic [COL_W-1:0]  col_q;
    logic [NKEYS-1:0]  raw_q, raw_d, prev_q, deb_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              slot_end, frame_done_q, fsm_tick_q;
    key_class_t        deb_cls;
    logic [CODE_W-1:0] deb_code;

    assign slot_end = (slot_q == SLOT_W'(SCAN_DIV - 1));
    assign deb_cls  = matrix_class(MAX_KEYS'(deb_q));
    assign deb_code = CODE_W'(lowest_set(MAX_KEYS'(deb_q)));

    // Closed contact reads 0 on its row while its column is driven low.
    always_comb begin
        raw_d = raw_q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (slot_end && col_q == COL_W'(c)) raw_d[r*COLS + c] = ~key_r[r];
            end
        end
        if (raw_q != prev_q)                                stab_d = STAB_W'(1);
        else if (stab_q == STAB_W'(DEBOUNCE_FRAMES))       stab_d = stab_q;
        else                                                stab_d = stab_q + STAB_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            slot_q       <= '0;
            col_q        <= '0;
            key_c        <= {{(COLS-1){1'b1}}, 1'b0};
            raw_q        <= '0;
            prev_q       <= '0;
            deb_q        <= '0;
            stab_q       <= '0;
            frame_done_q <= 1'b0;
            fsm_tick_q   <= 1'b0;
            ghost        <= 1'b0;
        end else begin
            raw_q        <= raw_d;
            frame_done_q <= slot_end && (col_q == COL_W'(COLS - 1));
            fsm_tick_q   <= frame_done_q;
            ghost        <= (deb_cls == KC_MULTI);
            if (slot_end) begin
                slot_q <= '0;
                col_q  <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
                key_c  <= {key_c[COLS-2:0], key_c[COLS-1]};
            end else begin
                slot_q <= slot_q + SLOT_W'(1);
            end
            if (frame_done_q) begin
                prev_q <= raw_q;
                stab_q <= stab_d;
                if (stab_d == STAB_W'(DEBOUNCE_FRAMES)) deb_q <= raw_q;
            end
        end
    end

    scan_state_t       state_q, state_d;
    logic              key_down_d, pend_q, pend_d, push_c;
    logic [CODE_W-1:0] key_code_d, pend_code_q, pend_code_d;
    logic [REP_W-1:0]  rep_q, rep_d, rep_inc, rep_lim;
    key_event_t        push_ev_c;

    // A key change while held emits the release now and the new press next cycle.
    always_comb begin
        state_d     = state_q;
        key_down_d  = key_down;
        key_code_d  = key_code;
        rep_d       = rep_q;
        pend_d      = 1'b0;
        pend_code_d = pend_code_q;
        push_c      = 1'b0;
        push_ev_c   = '0;
        rep_inc     = rep_q + REP_W'(1);
        rep_lim     = (state_q == ST_HELD) ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
        if (pend_q) begin
            push_c         = 1'b1;
            push_ev_c.code = MAX_CODE_W'(pend_code_q);
        end else if (fsm_tick_q) begin
            unique case (state_q)
                ST_IDLE, ST_MULTI: begin
                    if (deb_cls == KC_SINGLE) begin
                        push_c         = 1'b1;
                        push_ev_c.code = MAX_CODE_W'(deb_code);
                        key_down_d     = 1'b1;
                        key_code_d     = deb_code;
                        rep_d          = '0;
                        state_d        = ST_HELD;
                    end else if (deb_cls == KC_MULTI) begin
                        key_down_d = 1'b0;
                        state_d    = ST_MULTI;
                    end else begin
                        key_down_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                ST_HELD, ST_REPEAT: begin
                    if (deb_cls != KC_SINGLE) begin
                        push_c               = 1'b1;
                        push_ev_c.is_release = 1'b1;
                        push_ev_c.code       = MAX_CODE_W'(key_code);
                        key_down_d           = 1'b0;
                        state_d              = (deb_cls == KC_NONE) ? ST_IDLE : ST_MULTI;
                    end else if (deb_code != key_code) begin
                        push_c               = 1'b1;
                        push_ev_c.is_release = 1'b1;
                        push_ev_c.code       = MAX_CODE_W'(key_code);
                        pend_d               = 1'b1;
                        pend_code_d          = deb_code;
                        key_code_d           = deb_code;
                        rep_d                = '0;
                        state_d              = ST_HELD;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_inc == rep_lim) begin
                            push_c              = 1'b1;
                            push_ev_c.is_repeat = 1'b1;
                            push_ev_c.code      = MAX_CODE_W'(key_code);
                            rep_d               = '0;
                            state_d             = ST_REPEAT;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            key_down    <= 1'b0;
            key_code    <= '0;
            rep_q       <= '0;
            pend_q      <= 1'b0;
            pend_code_q <= '0;
        end else begin
            state_q     <= state_d;
            key_down    <= key_down_d;
            key_code    <= key_code_d;
            rep_q       <= rep_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
        end
    end

    // Code bits above CODE_W are always zero.
    logic unused_code_hi;
    assign unused_code_hi = ^push_ev_c.code;

    logic [CODE_W+1:0] head;

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W + 2)
    ) u_fifo (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .push      (push_c),
        .push_data ({push_ev_c.is_repeat, push_ev_c.is_release, push_ev_c.code[CODE_W-1:0]}),
        .ready     (ev_ready),
        .valid     (ev_valid),
        .head      (head),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    assign ev_repeat  = head[CODE_W+1];
    assign ev_release = head[CODE_W];
    assign ev_code    = head[CODE_W-1:0];

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed bench: two scanner instances (no-repeat/depth-2 and repeat/depth-4) on one clock.
module tb_keypad_event_scanner;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [15:0] pressed_a, pressed_b;
    logic [3:0]  key_r_a, key_c_a, ev_code_a, key_code_a;
    logic [3:0]  key_r_b, key_c_b, ev_code_b, key_code_b;
    logic ev_valid_a, ev_ready_a, ev_release_a, ev_repeat_a, key_down_a, ghost_a, ovf_a, ovf_clr_a;
    logic ev_valid_b, ev_ready_b, ev_release_b, ev_repeat_b, key_down_b, ghost_b, ovf_b, ovf_clr_b;

    function automatic logic [3:0] row_sense(input logic [15:0] p, input logic [3:0] kc);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (p[i*4 + j] && !kc[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign key_r_a = row_sense(pressed_a, key_c_a);
    assign key_r_b = row_sense(pressed_b, key_c_b);

    keypad_event_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(2),
        .REPEAT_EN(0), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .key_r(key_r_a), .key_c(key_c_a),
        .ev_valid(ev_valid_a), .ev_ready(ev_ready_a), .ev_code(ev_code_a),
        .ev_release(ev_release_a), .ev_repeat(ev_repeat_a), .key_down(key_down_a),
        .key_code(key_code_a), .ghost(ghost_a), .ovf(ovf_a), .ovf_clr(ovf_clr_a)
    );

    keypad_event_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4),
        .REPEAT_EN(1), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .key_r(key_r_b), .key_c(key_c_b),
        .ev_valid(ev_valid_b), .ev_ready(ev_ready_b), .ev_code(ev_code_b),
        .ev_release(ev_release_b), .ev_repeat(ev_repeat_b), .key_down(key_down_b),
        .key_code(key_code_b), .ghost(ghost_b), .ovf(ovf_b), .ovf_clr(ovf_clr_b)
    );

    typedef struct {
        logic [3:0]  code;
        logic        rel;
        logic        rpt;
        int unsigned cyc;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    // Record every accepted handshake; the pop itself happens on the next rising edge.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && ev_valid_a && ev_ready_a)
            q_a.push_back('{code: ev_code_a, rel: ev_release_a, rpt: ev_repeat_a, cyc: cyc});
        if (Rst_n === 1'b1 && ev_valid_b && ev_ready_b)
            q_b.push_back('{code: ev_code_b, rel: ev_release_b, rpt: ev_repeat_b, cyc: cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Align to the negedge just after column 0 becomes driven.
    task automatic sync_frame();
        logic [3:0] prev;
        int n;
        prev = key_c_a;
        n = 0;
        @(negedge Clk);
        while (!(prev == 4'b0111 && key_c_a == 4'b1110) && n < 64) begin
            prev = key_c_a;
            @(negedge Clk);
            n++;
        end
        check("sync_frame_timeout", 32'(n < 64), 32'd1);
    endtask

    initial begin
        Rst_n      = 1'b0;
        pressed_a  = '0;
        pressed_b  = '0;
        ev_ready_a = 1'b1;
        ev_ready_b = 1'b1;
        ovf_clr_a  = 1'b0;
        ovf_clr_b  = 1'b0;
        repeat (3) @(negedge Clk);

        check("rst_key_c",    32'(key_c_a),    32'h0E);
        check("rst_ev_valid", 32'(ev_valid_a), 32'd0);
        check("rst_ev_code",  32'(ev_code_a),  32'd0);
        check("rst_key_down", 32'(key_down_a), 32'd0);
        check("rst_ghost",    32'(ghost_a),    32'd0);
        check("rst_ovf",      32'(ovf_a),      32'd0);

        @(posedge Clk); #1 Rst_n = 1'b1;
        wait_cycles(40);

        // Single key row1/col2 -> one press, then one release.
        sync_frame();
        pressed_a = 16'h0040;
        wait_cycles(80);
        check("press6_count",   32'(q_a.size()), 32'd1);
        check("press6_code",    32'(q_a[0].code), 32'd6);
        check("press6_release", 32'(q_a[0].rel),  32'd0);
        check("press6_repeat",  32'(q_a[0].rpt),  32'd0);
        check("press6_keydown", 32'(key_down_a),  32'd1);
        check("press6_keycode", 32'(key_code_a),  32'd6);
        pressed_a = '0;
        wait_cycles(80);
        check("rel6_count",   32'(q_a.size()), 32'd2);
        check("rel6_code",    32'(q_a[1].code), 32'd6);
        check("rel6_release", 32'(q_a[1].rel),  32'd1);
        check("rel6_keydown", 32'(key_down_a),  32'd0);
        check("rel6_keycode", 32'(key_code_a),  32'd6);

        // Bounce on code 0: alternating frames never debounce.
        q_a.delete();
        sync_frame();
        for (int i = 0; i < 6; i++) begin
            pressed_a[0] = ~pressed_a[0];
            wait_cycles(16);
        end
        check("bounce_no_events", 32'(q_a.size()), 32'd0);
        pressed_a[0] = 1'b1;
        wait_cycles(24);
        check("settle_1frame_quiet", 32'(q_a.size()), 32'd0);
        wait_cycles(24);
        check("settle_press_count", 32'(q_a.size()), 32'd1);
        check("settle_press_code",  32'(q_a[0].code), 32'd0);
        check("settle_press_rel",   32'(q_a[0].rel),  32'd0);
        pressed_a = '0;
        wait_cycles(80);
        check("settle_rel_count", 32'(q_a.size()), 32'd2);
        check("settle_rel_flag",  32'(q_a[1].rel),  32'd1);

        // Ghost: codes 5 and 10 together, then drop 10.
        q_a.delete();
        sync_frame();
        pressed_a = 16'h0420;
        wait_cycles(80);
        check("ghost_flag",      32'(ghost_a),     32'd1);
        check("ghost_no_events", 32'(q_a.size()),  32'd0);
        check("ghost_keydown",   32'(key_down_a),  32'd0);
        pressed_a = 16'h0020;
        wait_cycles(80);
        check("ghost_clear",       32'(ghost_a),      32'd0);
        check("ghost_press_count", 32'(q_a.size()),   32'd1);
        check("ghost_press_code",  32'(q_a[0].code),  32'd5);
        check("ghost_press_rel",   32'(q_a[0].rel),   32'd0);
        check("ghost_keycode",     32'(key_code_a),   32'd5);
        check("ghost_keydown_1",   32'(key_down_a),   32'd1);
        pressed_a = '0;
        wait_cycles(80);

        // Auto-repeat on code 15: held frames 0..10 after sync, released mid frame 11.
        q_b.delete();
        sync_frame();
        pressed_b = 16'h8000;
        wait_cycles(16 * 11 + 8);
        pressed_b = '0;
        wait_cycles(64);
        check("rpt_count",      32'(q_b.size()), 32'd6);
        check("rpt_press_code", 32'(q_b[0].code), 32'd15);
        check("rpt_press_flag", 32'(q_b[0].rpt),  32'd0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("rpt%0d_code", i),   32'(q_b[i].code), 32'd15);
            check($sformatf("rpt%0d_flag", i),   32'(q_b[i].rpt),  32'd1);
            check($sformatf("rpt%0d_rel", i),    32'(q_b[i].rel),  32'd0);
            check($sformatf("rpt%0d_offset", i), 32'(q_b[i].cyc - q_b[0].cyc), 32'(16 * (2 * i + 1)));
        end
        check("rpt_release_code", 32'(q_b[5].code), 32'd15);
        check("rpt_release_flag", 32'(q_b[5].rel),  32'd1);
        check("rpt_release_rpt",  32'(q_b[5].rpt),  32'd0);

        // Overflow on the depth-2 FIFO.
        q_a.delete();
        @(posedge Clk); #1 ev_ready_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pressed_a = 16'h0008;
            wait_cycles(64);
            pressed_a = '0;
            wait_cycles(64);
        end
        check("ovf_valid",    32'(ev_valid_a),   32'd1);
        check("ovf_flag",     32'(ovf_a),        32'd1);
        check("ovf_head0",    32'(ev_code_a),    32'd3);
        check("ovf_head0_rel", 32'(ev_release_a), 32'd0);
        @(posedge Clk); #1 ovf_clr_a = 1'b1;
        @(posedge Clk); #1 ovf_clr_a = 1'b0;
        @(negedge Clk);
        check("ovf_cleared", 32'(ovf_a), 32'd0);
        @(posedge Clk); #1 ev_ready_a = 1'b1;
        @(posedge Clk); #1 ev_ready_a = 1'b0;
        @(negedge Clk);
        check("pop1_valid", 32'(ev_valid_a),   32'd1);
        check("pop1_code",  32'(ev_code_a),    32'd3);
        check("pop1_rel",   32'(ev_release_a), 32'd1);
        @(posedge Clk); #1 ev_ready_a = 1'b1;
        @(posedge Clk); #1 ev_ready_a = 1'b0;
        @(negedge Clk);
        check("pop2_empty", 32'(ev_valid_a), 32'd0);
        check("pop_count",  32'(q_a.size()), 32'd2);

        // Async reset mid-frame with a pending event.
        pressed_a = 16'h0200;
        wait_cycles(64);
        check("pre_rst_valid",   32'(ev_valid_a), 32'd1);
        check("pre_rst_keydown", 32'(key_down_a), 32'd1);
        begin
            int n;
            n = 0;
            while (key_c_a != 4'b1011 && n < 32) begin
                @(negedge Clk);
                n++;
            end
            check("pre_rst_col2", 32'(key_c_a), 32'h0B);
        end
        #2 Rst_n = 1'b0;
        #1;
        check("arst_key_c",      32'(key_c_a),      32'h0E);
        check("arst_ev_valid",   32'(ev_valid_a),   32'd0);
        check("arst_ev_code",    32'(ev_code_a),    32'd0);
        check("arst_ev_release", 32'(ev_release_a), 32'd0);
        check("arst_ev_repeat",  32'(ev_repeat_a),  32'd0);
        check("arst_key_down",   32'(key_down_a),   32'd0);
        check("arst_key_code",   32'(key_code_a),   32'd0);
        check("arst_ghost",      32'(ghost_a),      32'd0);
        check("arst_ovf",        32'(ovf_a),        32'd0);
        pressed_a = '0;
        @(posedge Clk); #1 Rst_n = 1'b1;
        wait_cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_event_scanner.md
Name: keypad_event_scanner

Overview:
Parametrised ROWSxCOLS matrix keypad scanner. Drives columns active-low one at a time, samples the rows, and debounces whole-matrix frames. Emits press/release/auto-repeat events into a small FIFO, read through a valid/ready handshake. Feeds the calculator input decoder and replaces the fixed 4x4 scan plus single-key filter pair.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column drive outputs (2..8)
SCAN_DIV, 50000, Clk cycles per column slot (>=4)
DEBOUNCE_FRAMES, 4, consecutive identical frames required before the debounced matrix updates (>=1)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
REPEAT_EN, 1, enables auto-repeat events
REPEAT_DELAY, 50, debounced frames a key is held before the first repeat
REPEAT_RATE, 10, frames between subsequent repeats
CODE_W, $clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
key_r  in  ROWS  row sense, pulled up externally; 0 = key closed in the driven column
key_c  out  COLS  column drive, active-low one-hot
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts head event
ev_code  out  CODE_W  head event key code = row*COLS + col
ev_release  out  1  head event is a release
ev_repeat  out  1  head event is an auto-repeat press
key_down  out  1  a single debounced key is currently held
key_code  out  CODE_W  code of the held key (holds last value when released)
ghost  out  1  debounced matrix has more than one key closed
ovf  out  1  sticky: an event was dropped on a full FIFO
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async assert, sync release): key_c = all ones except bit0 low; column index 0; slot counter 0; raw/prev/debounced matrices all zero; FIFO empty; ev_valid=0; ev_code/ev_release/ev_repeat=0; key_down=0; key_code=0; ghost=0; ovf=0; FSM IDLE.
- Scan: slot counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1: latch ~key_r into the raw row for the current column, then advance the column (wrap COLS-1 -> 0) and rotate key_c. The sample is taken SCAN_DIV-1 cycles after the drive change, which is the settle margin.
- Frame end: after column COLS-1 is sampled, the raw frame is complete and compared with the previous frame.
  - Equal: stable counter increments, saturating at DEBOUNCE_FRAMES.
  - Different: stable counter resets to 1.
  - When the counter equals DEBOUNCE_FRAMES, the debounced matrix loads the frame.
  - The FSM evaluates once per frame end, one cycle after the debounced update.
- Popcount of debounced matrix: 0 = none, 1 = single (code from lowest set bit), >1 = multi. ghost = multi.
- FSM states: IDLE, HELD, REPEAT, MULTI.
  - IDLE: single -> push press(code), key_down=1, key_code=code, repeat counter=0, go HELD. multi -> MULTI.
  - HELD: none -> push release(key_code), go IDLE. Multi -> push release(key_code), go MULTI. Different single -> push release(old) and, the next cycle, press(new); stay HELD. Same key with REPEAT_EN and counter reaching REPEAT_DELAY -> push repeat, counter=0, go REPEAT.
  - REPEAT: same key and counter reaching REPEAT_RATE -> push repeat, counter=0. Transitions out are the same as HELD.
  - MULTI: no events, key_down=0. None -> IDLE. Single -> treated as a new press (push press, go HELD).
- FIFO: entry = {repeat, release, code}.
  - Pop when ev_valid & ev_ready.
  - Head outputs are registered and change the cycle after a pop.
  - Push and pop in the same cycle when full: both succeed.
  - Push when full without a pop: event dropped, ovf=1.
  - ovf_clr and a new overflow in the same cycle: ovf stays 1.
- Events are at most two per frame, so there are no simultaneous-push conflicts.
- Reset mid-scan or mid-event: everything returns to reset values and pending FIFO contents are discarded.

Decomposition:
- Package keypad_pkg: FSM state enum, event struct {repeat, release, code}, and the popcount/lowest-set-bit function.
- Sub-module key_event_fifo (FIFO_DEPTH, width CODE_W+2) holds the synchronous FIFO and overflow flag.
- Scan, debounce and FSM stay in the top module.

Test Plan:
- Params ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_EN=0. Hold row1/col2 closed for 5 frames with ev_ready=1 -> exactly one press, ev_code=6, ev_release=0; key_down=1, key_code=6; on release, one release event with code 6.
- Bounce: toggle row0/col0 every frame for 6 frames, then hold -> no events during the bounce; a single press code 0 issued 2 frames after it settles.
- Ghost: close codes 5 and 10 together -> ghost=1, no events, key_down=0. Release 10 -> press code 5 pushed.
- Repeat: REPEAT_EN=1, REPEAT_DELAY=3, REPEAT_RATE=2, hold code 15 for 10 frames -> press, then repeats at frame offsets 3, 5, 7, 9 after the press, each with ev_repeat=1.
- Overflow: FIFO_DEPTH=2, ev_ready=0, press/release code 3 twice -> ev_valid=1, ovf=1, FIFO holds press3 and release3. Pulse ovf_clr -> ovf=0. Pop two entries -> ev_valid=0.
- Async reset asserted mid-frame with the FIFO non-empty -> all outputs reach reset values immediately; key_c returns to column-0 drive.
